// File: rtl/dadda_multiplier_24bit_pipelined.sv
// rtl/dadda_multiplier_24bit_pipelined.sv - unsigned 24x24 Dadda multiplier, two register stages, Kogge-Stone final adder
// Stage 1 reduces columns to height 6; stage 2 reduces to 2 rows; out is the prefix-adder sum of stage 2.
module dadda_multiplier_24bit_pipelined (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] in1,
   input  logic [23:0] in2,
   output logic [47:0] out
);

   // Column-major bit matrix: m[column][row], rows packed from 0 upward.
   typedef logic [47:0][23:0] mat_t;
   typedef logic [47:0][4:0]  hts_t;

   function automatic hts_t init_heights();
      hts_t h;
      for (int c = 0; c < 48; c++)
         h[6'(c)] = (c < 24) ? 5'(c + 1) : 5'(47 - c);
      return h;
   endfunction

   // Mirrors the adder placement of reduce_level so each level knows its input heights.
   function automatic hts_t next_heights(input hts_t h, input int d);
      hts_t r;
      int   t;
      int   carry;
      int   nc;
      r     = '0;
      carry = 0;
      for (int c = 0; c < 48; c++) begin
         t  = int'(h[6'(c)]) + carry;
         nc = 0;
         for (int k = 0; k < 16; k++) begin
            if (t > d) begin
               t  = (t == d + 1) ? t - 1 : t - 2;
               nc = nc + 1;
            end
         end
         r[6'(c)] = 5'(t);
         carry    = nc;
      end
      return r;
   endfunction

   localparam hts_t H0 = init_heights();
   localparam hts_t H1 = next_heights(H0, 19);
   localparam hts_t H2 = next_heights(H1, 13);
   localparam hts_t H3 = next_heights(H2, 9);
   localparam hts_t H4 = next_heights(H3, 6);
   localparam hts_t H5 = next_heights(H4, 4);
   localparam hts_t H6 = next_heights(H5, 3);

   // One Dadda level: per column, spend half/full adders only until the column
   // (including carries from the column below) fits in d bits.
   function automatic mat_t reduce_level(input mat_t m, input hts_t h, input int d);
      mat_t        r;
      logic [31:0] pool;
      logic [23:0] sums;
      logic [7:0]  cin;
      logic [7:0]  cout;
      logic        a;
      logic        b;
      logic        ci;
      int          n;
      int          ptr;
      int          nsum;
      int          ncin;
      int          ncout;
      int          rem;
      int          idx;
      r    = '0;
      cin  = '0;
      ncin = 0;
      for (int c = 0; c < 48; c++) begin
         pool = '0;
         n    = 0;
         for (int k = 0; k < 8; k++) begin
            if (k < ncin) begin
               pool[5'(n)] = cin[3'(k)];
               n = n + 1;
            end
         end
         for (int k = 0; k < 24; k++) begin
            if (k < int'(h[6'(c)])) begin
               pool[5'(n)] = m[6'(c)][5'(k)];
               n = n + 1;
            end
         end
         sums  = '0;
         cout  = '0;
         ncout = 0;
         nsum  = 0;
         ptr   = 0;
         for (int k = 0; k < 16; k++) begin
            rem = (n - ptr) + nsum;
            if (rem > d) begin
               a = pool[5'(ptr)];
               b = pool[5'(ptr + 1)];
               if (rem == d + 1) begin
                  sums[5'(nsum)]  = a ^ b;
                  cout[3'(ncout)] = a & b;
                  ptr = ptr + 2;
               end else begin
                  ci = pool[5'(ptr + 2)];
                  sums[5'(nsum)]  = a ^ b ^ ci;
                  cout[3'(ncout)] = (a & b) | (a & ci) | (b & ci);
                  ptr = ptr + 3;
               end
               nsum  = nsum + 1;
               ncout = ncout + 1;
            end
         end
         idx = 0;
         for (int k = 0; k < 24; k++) begin
            if (k < nsum) begin
               r[6'(c)][5'(idx)] = sums[5'(k)];
               idx = idx + 1;
            end
         end
         for (int k = 0; k < 32; k++) begin
            if (k >= ptr && k < n) begin
               r[6'(c)][5'(idx)] = pool[5'(k)];
               idx = idx + 1;
            end
         end
         cin  = cout;
         ncin = ncout;
      end
      return r;
   endfunction

   function automatic logic [47:0] get_row(input mat_t m, input int k);
      logic [47:0] r;
      for (int c = 0; c < 48; c++)
         r[6'(c)] = m[6'(c)][5'(k)];
      return r;
   endfunction

   mat_t        pp;
   mat_t        lvl1;
   mat_t        r1;
   mat_t        lvl2;
   logic [47:0] row_a;
   logic [47:0] row_b;
   logic [47:0] r2a;
   logic [47:0] r2b;
   logic [47:0] ksa_g;
   logic [47:0] ksa_p;
   logic [47:0] ksa_gn;

   // Partial products; columns at or above 24 start at row (i+j-23) so shift them down to row 0.
   always_comb begin
      pp = '0;
      for (int i = 0; i < 24; i++) begin
         for (int j = 0; j < 24; j++) begin
            if (i + j < 24)
               pp[6'(i + j)][5'(i)] = in1[5'(j)] & in2[5'(i)];
            else
               pp[6'(i + j)][5'(23 - j)] = in1[5'(j)] & in2[5'(i)];
         end
      end
      lvl1 = reduce_level(reduce_level(reduce_level(reduce_level(pp, H0, 19), H1, 13), H2, 9), H3, 6);
   end

   always_comb begin
      lvl2  = reduce_level(reduce_level(reduce_level(r1, H4, 4), H5, 3), H6, 2);
      row_a = get_row(lvl2, 0);
      row_b = get_row(lvl2, 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1  <= '0;
         r2a <= '0;
         r2b <= '0;
      end else begin
         r1  <= lvl1;
         r2a <= row_a;
         r2b <= row_b;
      end
   end

   // Kogge-Stone: six prefix levels (spans 1..32) cover all 48 bit positions.
   always_comb begin
      ksa_g  = r2a & r2b;
      ksa_p  = r2a ^ r2b;
      ksa_gn = '0;
      for (int l = 0; l < 6; l++) begin
         ksa_gn = ksa_g | (ksa_p & (ksa_g << (1 << l)));
         ksa_p  = ksa_p & (ksa_p << (1 << l));
         ksa_g  = ksa_gn;
      end
      out = (r2a ^ r2b) ^ (ksa_g << 1);
   end

endmodule

// File: tb/tb_dadda_multiplier_24bit_pipelined.sv
// tb/tb_dadda_multiplier_24bit_pipelined.sv - scoreboard bench for the pipelined 24x24 multiplier
module tb_dadda_multiplier_24bit_pipelined;

   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] in1;
   logic [23:0] in2;
   logic [47:0] out;

   logic        v_in;
   logic        vd1;
   logic        vd2;
   logic [47:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   dadda_multiplier_24bit_pipelined dut (
      .clk(clk),
      .rst(rst),
      .in1(in1),
      .in2(in2),
      .out(out)
   );

   always #5 clk = ~clk;

   // Expected arrival: a pair driven before edge E is on out after the following edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vd1 <= 1'b0;
         vd2 <= 1'b0;
      end else begin
         vd1 <= v_in;
         vd2 <= vd1;
      end
   end

   always @(negedge clk) begin
      logic [47:0] e;
      if (vd2) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_underflow out=%h expected=<none>", out);
         end else begin
            e = exp_q.pop_front();
            if (out !== e) begin
               errors++;
               $display("FAIL stream out=%h expected=%h", out, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s out=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [47:0] e);
      @(negedge clk);
      in1  = a;
      in2  = b;
      v_in = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         in1  = '0;
         in2  = '0;
         v_in = 1'b0;
      end
   endtask

   logic [23:0] va[10];
   logic [23:0] vb[10];
   logic [47:0] ve[10];

   initial begin
      logic [23:0] a;
      logic [23:0] b;
      va[0] = 24'hFFFFFF; vb[0] = 24'hFFFFFF; ve[0] = 48'hFFFFFE000001;
      va[1] = 24'h800000; vb[1] = 24'h800000; ve[1] = 48'h400000000000;
      va[2] = 24'h800000; vb[2] = 24'hC00000; ve[2] = 48'h600000000000;
      va[3] = 24'h000000; vb[3] = 24'hABCDEF; ve[3] = 48'h000000000000;
      va[4] = 24'h000001; vb[4] = 24'hABCDEF; ve[4] = 48'h000000ABCDEF;
      va[5] = 24'hFFFFFF; vb[5] = 24'h000001; ve[5] = 48'h000000FFFFFF;
      va[6] = 24'h800001; vb[6] = 24'hFFFFFF; ve[6] = 48'h8000007FFFFF;
      va[7] = 24'hFFFFFF; vb[7] = 24'h800000; ve[7] = 48'h7FFFFF800000;
      va[8] = 24'h000002; vb[8] = 24'h400000; ve[8] = 48'h000000800000;
      va[9] = 24'h000010; vb[9] = 24'h000010; ve[9] = 48'h000000000100;

      rst  = 1'b1;
      v_in = 1'b0;
      in1  = '0;
      in2  = '0;
      #1;
      check("reset_out", out, 48'h0);
      idle(2);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) issue(va[i], vb[i], ve[i]);
      idle(3);

      for (int i = 0; i < 1000; i++) begin
         case (i % 4)
            0: begin a = 24'($urandom); b = 24'($urandom); end
            1: begin a = 24'hFFFFFF;    b = 24'($urandom); end
            2: begin a = 24'h1 << (i % 24); b = 24'h1 << ((i * 7) % 24); end
            default: begin a = 24'($urandom); b = 24'hFFFFFF; end
         endcase
         issue(a, b, {24'h0, a} * {24'h0, b});
      end

      // Asynchronous reset with the pipeline full of nonzero products.
      issue(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
      issue(24'hABCDEF, 24'h123456, {24'h0, 24'hABCDEF} * {24'h0, 24'h123456});
      issue(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
      @(posedge clk);
      #2;
      check("pre_reset_nonzero", 48'(out != 48'h0), 48'h1);
      rst  = 1'b1;
      v_in = 1'b0;
      in1  = 24'hFFFFFF;
      in2  = 24'hFFFFFF;
      exp_q.delete();
      #1;
      check("async_reset_out", out, 48'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("reset_held_out", out, 48'h0);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      in1 = '0;
      in2 = '0;
      @(negedge clk);
      check("post_release_out", out, 48'h0);
      in1  = 24'h800000;
      in2  = 24'h800000;
      v_in = 1'b1;
      exp_q.push_back(48'h400000000000);
      @(negedge clk);
      check("no_stale_out", out, 48'h0);
      in1  = 24'h800001;
      in2  = 24'hFFFFFF;
      exp_q.push_back(48'h8000007FFFFF);
      idle(1);

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout time=%0t limit=200000", $time);
      $fatal(1, "timeout");
   end

endmodule
